// File: rtl/fbp_array_loader.sv
// fbp_array_loader: assembles the find_bit_pattern page array from a word
// stream, holds the four match patterns, and sequences the block epochs
// (one strobe per block plus a final aggregation flush) before signalling
// frame completion.
module fbp_array_loader #(
    parameter int WORD_W    = 32,
    parameter int ARR_SIZE  = 288,
    parameter int P_SIZE    = 12,
    parameter int NOB       = 3,
    parameter int NOB_WIDTH = 2,
    parameter int GAP       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [P_SIZE-1:0]     cfg_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_last,
    output logic [ARR_SIZE-1:0]   a,
    output logic [P_SIZE-1:0]     x1,
    output logic [P_SIZE-1:0]     x2,
    output logic [P_SIZE-1:0]     x3,
    output logic [P_SIZE-1:0]     x4,
    output logic [NOB_WIDTH:0]    b_idx,
    output logic                  put_global_array,
    output logic                  busy,
    output logic                  done,
    output logic                  done_err
);

    localparam int NWORDS = ARR_SIZE / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [NOB_WIDTH:0] LAST_BLK  = (NOB_WIDTH + 1)'(NOB - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_PULSE = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [GAP_W-1:0]      r_wcnt;
    logic [ARR_SIZE-1:0]   r_a;
    logic [P_SIZE-1:0]     r_x1;
    logic [P_SIZE-1:0]     r_x2;
    logic [P_SIZE-1:0]     r_x3;
    logic [P_SIZE-1:0]     r_x4;
    logic [NOB_WIDTH:0]    r_b_idx;
    logic                  r_pga;
    logic                  r_done;
    logic                  r_done_err;
    logic                  r_err;
    logic                  r_flushed;

    logic                  w_accept;
    logic                  w_frame_end;
    logic                  w_wait_end;
    logic                  w_frame_bad;

    // A word is taken only in LOAD and never while reset is asserted.
    assign w_accept    = s_valid && (r_state == S_LOAD) && !rst;
    // The frame closes on s_last or on the final word slot, whichever is first.
    assign w_frame_end = w_accept && (s_last || (r_cnt == LAST_WORD));
    // Length is wrong if s_last comes early or never comes by the final slot.
    assign w_frame_bad = (s_last && (r_cnt != LAST_WORD)) || (!s_last && (r_cnt == LAST_WORD));
    assign w_wait_end  = (r_state == S_WAIT) && (r_wcnt == GAP_LAST);

    // State register for the epoch sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: load, then one pulse per block, one flush, done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_frame_end) begin
                    w_state_nxt = S_PULSE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_PULSE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_wait_end) begin
                    w_state_nxt = S_WAIT;
                end else if (r_b_idx < LAST_BLK) begin
                    w_state_nxt = S_PULSE;
                end else if (!r_flushed) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_FLUSH: w_state_nxt = S_WAIT;
            S_DONE:  w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Datapath: array assembly, pattern registers, epoch counters, strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_wcnt     <= '0;
            r_a        <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_x3       <= '0;
            r_x4       <= '0;
            r_b_idx    <= '0;
            r_pga      <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            r_err      <= 1'b0;
            r_flushed  <= 1'b0;
        end else begin
            // Patterns only change while idle so a scan sees stable values.
            if (cfg_we && (r_state == S_LOAD)) begin
                case (cfg_sel)
                    2'd0:    r_x1 <= cfg_data;
                    2'd1:    r_x2 <= cfg_data;
                    2'd2:    r_x3 <= cfg_data;
                    2'd3:    r_x4 <= cfg_data;
                    default: r_x1 <= r_x1;
                endcase
            end

            r_pga      <= (w_state_nxt == S_PULSE) || (w_state_nxt == S_FLUSH);
            r_done     <= (w_state_nxt == S_DONE);
            r_done_err <= (w_state_nxt == S_DONE) && r_err;

            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            if (r_cnt == CNT_W'(i)) begin
                                r_a[ARR_SIZE-1-i*WORD_W -: WORD_W] <= s_data;
                            end
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_frame_end) begin
                        r_err   <= w_frame_bad;
                        r_b_idx <= '0;
                        r_wcnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_wait_end) begin
                        r_wcnt <= '0;
                        if (r_b_idx < LAST_BLK) begin
                            r_b_idx <= r_b_idx + (NOB_WIDTH + 1)'(1);
                        end else if (!r_flushed) begin
                            r_flushed <= 1'b1;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    r_a       <= '0;
                    r_cnt     <= '0;
                    r_err     <= 1'b0;
                    r_b_idx   <= '0;
                    r_flushed <= 1'b0;
                end
                default: begin
                    r_wcnt <= r_wcnt;
                end
            endcase
        end
    end

    assign s_ready          = !rst && (r_state == S_LOAD);
    assign busy             = (r_state != S_LOAD);
    assign a                = r_a;
    assign x1               = r_x1;
    assign x2               = r_x2;
    assign x3               = r_x3;
    assign x4               = r_x4;
    assign b_idx            = r_b_idx;
    assign put_global_array = r_pga;
    assign done             = r_done;
    assign done_err         = r_done_err;

endmodule

// File: tb/tb_fbp_array_loader.sv
// Self-checking bench for fbp_array_loader: frames with random content,
// bubbles and length errors, checked cycle by cycle against a timeline
// computed from the epoch/gap arithmetic.
module tb_fbp_array_loader;

    localparam int G        = 3;
    localparam int NW       = 9;
    localparam int DONE_OFF = 5 + 4 * G;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [11:0]   cfg_data;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          s_last;
    logic [287:0]  a;
    logic [11:0]   x1, x2, x3, x4;
    logic [2:0]    b_idx;
    logic          put_global_array;
    logic          busy;
    logic          done;
    logic          done_err;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [11:0]   exp_x [4];
    logic [287:0]  exp_a;
    bit            exp_err;
    logic [31:0]   words [NW];
    logic [31:0]   tenth_word;

    // Free-running clock.
    always #5 clk = ~clk;

    fbp_array_loader dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .a(a), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .b_idx(b_idx),
        .put_global_array(put_global_array), .busy(busy), .done(done), .done_err(done_err)
    );

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [11:0] d);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
        exp_x[sel] = d;
    endtask

    task automatic rand_words();
        for (int k = 0; k < NW; k++) words[k] = $urandom;
    endtask

    // Streams words[0..n-1]; returns positioned one step after the edge that took the last word.
    task automatic send_frame(input int n, input bit last_on_n, input bit bubbles, input bit hold);
        int  idx = 0;
        int  budget = 0;
        bit  drove;
        bit  rdy;
        exp_a = '0;
        for (int k = 0; k < n; k++) exp_a[287-32*k -: 32] = words[k];
        exp_err = (n < NW) || !last_on_n;
        while (idx < n && budget < 200) begin
            drove   = !(bubbles && ($urandom_range(0, 1) == 0));
            s_valid = drove;
            s_data  = words[idx];
            s_last  = last_on_n && (idx == n - 1);
            rdy     = s_ready;
            tick();
            budget++;
            if (drove && rdy) idx++;
        end
        chk("frame_accepted_words", 288'(idx), 288'(n));
        s_last = 1'b0;
        if (hold) begin
            s_valid = 1'b1;
            s_data  = tenth_word;
        end else begin
            s_valid = 1'b0;
        end
    endtask

    // Walks the scan timeline from the cycle after the last word through done+1.
    task automatic check_scan(input bit cfg_probe);
        bit          in_scan;
        bit          exp_pga;
        logic [2:0]  exp_b;
        for (int off = 1; off <= DONE_OFF + 1; off++) begin
            in_scan = (off <= DONE_OFF);
            exp_pga = (off == 1) || (off == 2 + G) || (off == 3 + 2 * G) || (off == 4 + 3 * G);
            if (!in_scan)            exp_b = 3'd0;
            else if (off < 2 + G)    exp_b = 3'd0;
            else if (off < 3 + 2*G)  exp_b = 3'd1;
            else                     exp_b = 3'd2;
            chk("pga",      288'(put_global_array), 288'(exp_pga));
            chk("b_idx",    288'(b_idx),            288'(exp_b));
            chk("done",     288'(done),             288'(off == DONE_OFF));
            chk("done_err", 288'(done_err),         288'((off == DONE_OFF) && exp_err));
            chk("s_ready",  288'(s_ready),          288'(!in_scan));
            chk("busy",     288'(busy),             288'(in_scan));
            chk("a",        a,                      in_scan ? exp_a : 288'd0);
            chk("x", 288'({x1, x2, x3, x4}), 288'({exp_x[0], exp_x[1], exp_x[2], exp_x[3]}));
            if (cfg_probe) begin
                cfg_we   = (off == 3);
                cfg_sel  = 2'd0;
                cfg_data = 12'hFFF;
            end
            if (in_scan) tick();
        end
        cfg_we = 1'b0;
    endtask

    // Main sequence.
    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        for (int i = 0; i < 4; i++) exp_x[i] = '0;
        tick();
        tick();
        chk("rst_a",        a,                         288'd0);
        chk("rst_x",        288'({x1, x2, x3, x4}),    288'd0);
        chk("rst_b_idx",    288'(b_idx),               288'd0);
        chk("rst_pga",      288'(put_global_array),    288'd0);
        chk("rst_done",     288'({done, done_err}),    288'd0);
        chk("rst_busy",     288'(busy),                288'd0);
        chk("rst_s_ready",  288'(s_ready),             288'd0);
        rst = 1'b0;
        #1;
        chk("idle_s_ready", 288'(s_ready), 288'd1);

        // Directed frame with the reference pattern set.
        cfg_write(2'd0, 12'h111);
        cfg_write(2'd1, 12'h222);
        cfg_write(2'd2, 12'h333);
        cfg_write(2'd3, 12'h444);
        chk("x_loaded", 288'({x1, x2, x3, x4}), 288'(48'h111_222_333_444));
        words = '{32'h11123456, 32'h7890abc2, 32'h22333012, 32'h12323411, 32'h13454446,
                  32'h78abc111, 32'h66677788, 32'h81112226, 32'h66000fff};
        send_frame(NW, 1'b1, 1'b0, 1'b0);
        chk("a_directed", a, 288'h11123456_7890abc2_22333012_12323411_13454446_78abc111_66677788_81112226_66000fff);
        check_scan(1'b0);

        // Same frame with bubbles; a pattern write during the scan must be ignored.
        send_frame(NW, 1'b1, 1'b1, 1'b0);
        check_scan(1'b1);
        cfg_write(2'd0, 12'hFFF);
        chk("x1_after_done", 288'(x1), 288'(12'hFFF));

        // Short frame: s_last on the third word.
        rand_words();
        send_frame(3, 1'b1, 1'b0, 1'b0);
        check_scan(1'b0);

        // Missing s_last, with a tenth word held valid through the scan.
        rand_words();
        tenth_word = $urandom;
        send_frame(NW, 1'b0, 1'b0, 1'b1);
        check_scan(1'b0);
        tick();
        chk("tenth_word_taken", 288'(a[287:256]), 288'(tenth_word));
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_x[i] = '0;

        // Reset during the epoch-1 pulse.
        cfg_write(2'd2, 12'h5A5);
        rand_words();
        send_frame(NW, 1'b1, 1'b0, 1'b0);
        for (int off = 1; off < 2 + G; off++) tick();
        chk("epoch1_pga",   288'(put_global_array), 288'd1);
        chk("epoch1_b_idx", 288'(b_idx),            288'd1);
        rst = 1'b1;
        tick();
        chk("abort_a",       a,                        288'd0);
        chk("abort_x",       288'({x1, x2, x3, x4}),   288'd0);
        chk("abort_b_idx",   288'(b_idx),              288'd0);
        chk("abort_strobes", 288'({put_global_array, done, done_err, busy, s_ready}), 288'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_x[i] = '0;
        for (int c = 0; c < 25; c++) begin
            chk("abort_quiet", 288'({put_global_array, done}), 288'd0);
            tick();
        end
        rand_words();
        send_frame(NW, 1'b1, 1'b0, 1'b0);
        check_scan(1'b0);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            int  n;
            bit  lst;
            cfg_write(2'($urandom_range(0, 3)), 12'($urandom));
            rand_words();
            n   = $urandom_range(1, NW);
            lst = (n < NW) ? 1'b1 : 1'($urandom_range(0, 1));
            send_frame(n, lst, 1'($urandom_range(0, 1)), 1'b0);
            check_scan(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
